uart_boot_loader: RTL
=====================

// Module: uart_boot_loader
// PURPOSE
//  Receives a program image over the board UART RX pin (8N1) and writes it word-by-word
//  into the single-port BSRAM. This replaces the hard-coded boot table as the boot source.
//  Drives boot_mode high until a complete, valid image is stored. The top level muxes
//  mem_addr/din/ce/wre into the BSRAM while boot_mode=1, then releases the BSRAM to the CPU.
// PARAMETERS
//  CLK_HZ  27_000_000  system clock frequency (Hz)
//  BAUD    115_200     UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, >=4 required)
//  ADDR_W  11          BSRAM word-address width
// PORTS
//  clk          in   1       system clock
//  rst_n        in   1       asynchronous active-low reset
//  uart_rx      in   1       serial input, idle high, async to clk
//  boot_mode    out  1       1 while loading; 0 once image accepted
//  mem_addr     out  ADDR_W  BSRAM word address
//  mem_din      out  16      BSRAM write data
//  mem_ce       out  1       BSRAM chip enable
//  mem_wre      out  1       BSRAM write enable, single-cycle pulse
//  words_loaded out  9       words written in the current frame
//  error        out  1       sticky: framing or checksum error seen since reset
// BEHAVIOUR
//  Reset values: boot_mode=1, mem_addr=0, mem_din=0, mem_ce=1, mem_wre=0, words_loaded=0, error=0.
//  RX path:
//   - uart_rx goes through a 2-flop synchronizer (2-cycle latency).
//   - Start is a synchronized 1->0 edge. The bit is re-sampled at CLKS_PER_BIT/2; if it
//     is high there, treat it as a glitch and return to idle.
//   - Data is sampled LSB first, once every CLKS_PER_BIT.
//   - Stop bit sampled low = framing error.
//   - A good byte yields a one-cycle internal rx_valid pulse with rx_byte.
//  Frame format: 0xA5 (sync), N (word count, 0..255), N x {lo byte, hi byte}, then CHK
//  (checksum byte, only with the optional feature enabled).
//  FSM, advanced only on rx_valid:
//   - WAIT_SYNC:
//       - Byte == 0xA5 -> GET_COUNT, clearing mem_addr, words_loaded and sum.
//       - Any other byte is dropped.
//   - GET_COUNT:
//       - Latch N.
//       - N=0 -> GET_CHK, or DONE if the feature is off.
//       - Otherwise -> GET_LO.
//   - GET_LO: latch lo byte -> GET_HI.
//   - GET_HI:
//       - Cycle after the hi byte: mem_din={hi,lo} and mem_wre=1 for exactly one cycle.
//       - mem_addr is stable during that pulse and increments the cycle after.
//       - words_loaded increments together with mem_addr.
//       - If words_loaded reaches N -> GET_CHK (or DONE); otherwise -> GET_LO.
//   - DONE:
//       - boot_mode=0 and mem_wre=0. State is held until reset; further RX bytes are ignored.
//  Arithmetic rules:
//   - mem_addr wraps modulo 2^ADDR_W.
//   - sum is 8-bit modulo-256 addition of data bytes only (not sync, count or CHK).
//  Errors:
//   - Framing error in any state: set error, return to WAIT_SYNC, boot_mode stays 1,
//     and the byte is discarded.
//   - Framing error in DONE is ignored.
//   - Memory already written is not rolled back; a retransmitted frame overwrites it from address 0.
//  Boundary cases:
//   - rx_valid can never coincide with the write cycle, because bytes are >=10*CLKS_PER_BIT apart.
//   - A sync byte received mid-frame is treated as data, not as a resync.
//  Reset asserted mid-frame: all state returns to reset values immediately; a write in flight
//  is aborted.
// CONFIGURATION
//  BOOT_CHECKSUM_EN defined:
//   - A trailing CHK byte is expected after the last word.
//   - CHK == sum -> DONE.
//   - Mismatch -> set error and return to WAIT_SYNC, with boot_mode still 1.
//  BOOT_CHECKSUM_EN undefined:
//   - No GET_CHK state; DONE is entered the cycle after the last write.
//   - The sum logic is not built.
// TESTING (CLK_HZ=16, BAUD=1 -> 16 clocks/bit)
//  1. A5,02,A1,00,78,00[,19 if BOOT_CHECKSUM_EN]
//     -> writes 0x00A1@0, then 0x0078@1; words_loaded=2; boot_mode falls; error=0.
//  2. Bytes 3C,A5,00[,00] -> 3C dropped; no mem_wre pulse; DONE reached with words_loaded=0.
//  3. 1-clock low glitch on uart_rx -> no byte decoded; state remains WAIT_SYNC.
//  4. Stop bit driven 0 on the count byte -> error=1, back to WAIT_SYNC; a following good
//     frame still loads and reaches DONE with error still 1.
//  5. BOOT_CHECKSUM_EN: A5,01,01,00,FF -> word 0x0001 written@0, error=1, boot_mode stays 1.
//  6. rst_n pulsed low after the lo byte of word 1 -> all outputs back to reset values and
//     no further mem_wre; after that, A5,01,34,12[,46] writes 0x1234@0 and reaches DONE.

Source files
------------

// File: rtl/uart_boot_loader.sv
// Receives an 8N1 boot image on uart_rx and writes it word by word into BSRAM; holds boot_mode high until the image is accepted.
// Latency: 2-cycle RX synchronizer; mem_wre pulses the cycle after a hi byte's stop-bit sample; DONE follows the last write.
// Backpressure: none, bytes arrive at line rate. BOOT_CHECKSUM_EN adds a trailing checksum byte check.
module uart_boot_loader #(
    parameter int CLK_HZ = 27_000_000,
    parameter int BAUD   = 115_200,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    output logic              boot_mode,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_ce,
    output logic              mem_wre,
    output logic [8:0]        words_loaded,
    output logic              error
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        WAIT_SYNC,
        GET_COUNT,
        GET_LO,
        GET_HI,
        WRITE_WORD,
`ifdef BOOT_CHECKSUM_EN
        GET_CHK,
`endif
        DONE
    } boot_state_t;

`ifdef BOOT_CHECKSUM_EN
    localparam boot_state_t END_STATE = GET_CHK;
`else
    localparam boot_state_t END_STATE = DONE;
`endif

    logic              rx_meta_q, rx_meta_d;
    logic              rx_sync_q, rx_sync_d;
    logic              rx_prev_q, rx_prev_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]       mem_din_q, mem_din_d;
    logic              mem_wre_q, mem_wre_d;
    logic [8:0]        words_loaded_q, words_loaded_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        lo_q, lo_d;
    logic              error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              stop_sample;
    logic              rx_valid;
    logic              frame_err;
    logic [7:0]        rx_byte;
    logic [8:0]        words_inc;

    assign words_inc = words_loaded_q + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= RX_IDLE;
            rx_cnt_q       <= '0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            state_q        <= WAIT_SYNC;
            mem_addr_q     <= '0;
            mem_din_q      <= '0;
            mem_wre_q      <= 1'b0;
            words_loaded_q <= '0;
            count_q        <= '0;
            lo_q           <= '0;
            error_q        <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            rx_meta_q      <= rx_meta_d;
            rx_sync_q      <= rx_sync_d;
            rx_prev_q      <= rx_prev_d;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            state_q        <= state_d;
            mem_addr_q     <= mem_addr_d;
            mem_din_q      <= mem_din_d;
            mem_wre_q      <= mem_wre_d;
            words_loaded_q <= words_loaded_d;
            count_q        <= count_d;
            lo_q           <= lo_d;
            error_q        <= error_d;
`ifdef BOOT_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    // Receiver: the start bit is re-checked at mid-bit, data and stop bits at their centres.
    always_comb begin
        rx_meta_d  = uart_rx;
        rx_sync_d  = rx_meta_q;
        rx_prev_d  = rx_sync_q;
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == CNT_HALF) begin
                    rx_cnt_d   = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d  = '0;
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == CNT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        stop_sample = (rx_state_q == RX_STOP) && (rx_cnt_q == CNT_LAST);
        rx_valid    = stop_sample && rx_sync_q;
        frame_err   = stop_sample && !rx_sync_q;
        rx_byte     = shift_q;
    end

    always_comb begin
        state_d        = state_q;
        mem_addr_d     = mem_addr_q;
        mem_din_d      = mem_din_q;
        mem_wre_d      = 1'b0;
        words_loaded_d = words_loaded_q;
        count_d        = count_q;
        lo_d           = lo_q;
        error_d        = error_q;
`ifdef BOOT_CHECKSUM_EN
        sum_d          = sum_q;
`endif
        if (frame_err && state_q != DONE) begin
            error_d = 1'b1;
            state_d = WAIT_SYNC;
        end else begin
            case (state_q)
                WAIT_SYNC: begin
                    if (rx_valid && rx_byte == 8'hA5) begin
                        state_d        = GET_COUNT;
                        mem_addr_d     = '0;
                        words_loaded_d = '0;
`ifdef BOOT_CHECKSUM_EN
                        sum_d          = '0;
`endif
                    end
                end
                GET_COUNT: begin
                    if (rx_valid) begin
                        count_d = rx_byte;
                        state_d = (rx_byte == 8'd0) ? END_STATE : GET_LO;
                    end
                end
                GET_LO: begin
                    if (rx_valid) begin
                        lo_d    = rx_byte;
                        state_d = GET_HI;
`ifdef BOOT_CHECKSUM_EN
                        sum_d   = sum_q + rx_byte;
`endif
                    end
                end
                GET_HI: begin
                    if (rx_valid) begin
                        mem_din_d = {rx_byte, lo_q};
                        mem_wre_d = 1'b1;
                        state_d   = WRITE_WORD;
`ifdef BOOT_CHECKSUM_EN
                        sum_d     = sum_q + rx_byte;
`endif
                    end
                end
                // mem_wre is high in this state; the address advances once the pulse is over.
                WRITE_WORD: begin
                    mem_addr_d     = mem_addr_q + ADDR_W'(1);
                    words_loaded_d = words_inc;
                    state_d        = (words_inc == {1'b0, count_q}) ? END_STATE : GET_LO;
                end
`ifdef BOOT_CHECKSUM_EN
                GET_CHK: begin
                    if (rx_valid) begin
                        if (rx_byte == sum_q) begin
                            state_d = DONE;
                        end else begin
                            error_d = 1'b1;
                            state_d = WAIT_SYNC;
                        end
                    end
                end
`endif
                DONE: state_d = DONE;
                default: state_d = WAIT_SYNC;
            endcase
        end
    end

    always_comb begin
        boot_mode    = (state_q != DONE);
        mem_addr     = mem_addr_q;
        mem_din      = mem_din_q;
        mem_ce       = 1'b1;
        mem_wre      = mem_wre_q;
        words_loaded = words_loaded_q;
        error        = error_q;
    end

endmodule
